// File: rtl/puf_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : puf_pkg                                                       |
// | Brief  : Shared widths and FSM state encoding for the PUF sequencer.   |
// | Rev    : 1.0                                                           |
// +------------------------------------------------------------------------+
package puf_pkg;
  localparam int CHAL_W = 128;
  localparam int RESP_W = 16;
  localparam int VOTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_FIRE   = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_e;
endpackage
`default_nettype wire

// File: rtl/puf_eval_controller_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : puf_eval_controller_if                                        |
// | Brief  : Host handshake and PUF array signals of the sequencer.        |
// | Rev    : 1.0                                                           |
// +------------------------------------------------------------------------+
interface puf_eval_controller_if;
  import puf_pkg::*;

  logic              start;
  logic [CHAL_W-1:0] challenge_in;
  logic [RESP_W-1:0] a_in;
  logic [RESP_W-1:0] b_in;
  logic              busy;
  logic              done;
  logic [RESP_W-1:0] response_out;
  logic [RESP_W-1:0] stable_mask;
  logic [CHAL_W-1:0] puf_challenge;
  logic [RESP_W-1:0] puf_a;
  logic [RESP_W-1:0] puf_b;
  logic              puf_trigger;
  logic              puf_reset;
  logic [RESP_W-1:0] puf_response;

  // The sequencer is the slave of the host handshake.
  modport slave (
    input  start, challenge_in, a_in, b_in, puf_response,
    output busy, done, response_out, stable_mask,
           puf_challenge, puf_a, puf_b, puf_trigger, puf_reset
  );

  modport master (
    output start, challenge_in, a_in, b_in, puf_response,
    input  busy, done, response_out, stable_mask,
           puf_challenge, puf_a, puf_b, puf_trigger, puf_reset
  );
endinterface
`default_nettype wire

// File: rtl/puf_resp_sync.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : puf_resp_sync                                                 |
// | Brief  : Two-flop synchronizer for the asynchronous arbiter outputs.   |
// | Rev    : 1.0                                                           |
// +------------------------------------------------------------------------+
module puf_resp_sync #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule
`default_nettype wire

// File: rtl/puf_eval_controller.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : puf_eval_controller                                           |
// | Brief  : Repeats PUF evaluations and majority-votes each response bit. |
// | Rev    : 1.0                                                           |
// +------------------------------------------------------------------------+
module puf_eval_controller
  import puf_pkg::*;
#(
  parameter int NUM_EVAL      = 15,
  parameter int RESET_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  puf_eval_controller_if.slave  bus
);
  localparam int PH_MAX = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam logic [PH_W-1:0]   PH_RESET  = PH_W'(RESET_CYCLES - 1);
  localparam logic [PH_W-1:0]   PH_SETTLE = PH_W'(SETTLE_CYCLES - 1);
  localparam logic [VOTE_W-1:0] LAST_EVAL = VOTE_W'(NUM_EVAL - 1);
  localparam logic [VOTE_W-1:0] HALF      = VOTE_W'(NUM_EVAL / 2);
  localparam logic [VOTE_W-1:0] ALL_ONES  = VOTE_W'(NUM_EVAL);

  state_e            state_q;
  logic [PH_W-1:0]   phase_q;
  logic [VOTE_W-1:0] eval_q;
  logic [VOTE_W-1:0] vote_q [RESP_W];
  logic [VOTE_W-1:0] vote_d [RESP_W];
  logic [RESP_W-1:0] resp_d;
  logic [RESP_W-1:0] mask_d;
  logic [RESP_W-1:0] resp_s;

  logic              busy_q;
  logic              done_q;
  logic [RESP_W-1:0] resp_q;
  logic [RESP_W-1:0] mask_q;
  logic              trig_q;
  logic              prst_q;
  logic [CHAL_W-1:0] chal_q;
  logic [RESP_W-1:0] a_q;
  logic [RESP_W-1:0] b_q;

  puf_resp_sync #(.WIDTH(RESP_W)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (bus.puf_response),
    .q_o   (resp_s)
  );

  // Vote including the current sample, so DONE can present the final result.
  always_comb begin
    for (int i = 0; i < RESP_W; i++) begin
      vote_d[i] = vote_q[i] + VOTE_W'(resp_s[i]);
      resp_d[i] = (vote_d[i] > HALF);
      mask_d[i] = (vote_d[i] == '0) || (vote_d[i] == ALL_ONES);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      eval_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      resp_q  <= '0;
      mask_q  <= '0;
      trig_q  <= 1'b0;
      prst_q  <= 1'b1;
      chal_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      for (int i = 0; i < RESP_W; i++) vote_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          prst_q <= 1'b1;
          trig_q <= 1'b0;
          if (bus.start) begin
            chal_q  <= bus.challenge_in;
            a_q     <= bus.a_in;
            b_q     <= bus.b_in;
            eval_q  <= '0;
            phase_q <= PH_RESET;
            busy_q  <= 1'b1;
            state_q <= ST_ARM;
            for (int i = 0; i < RESP_W; i++) vote_q[i] <= '0;
          end
        end
        ST_ARM: begin
          if (phase_q == '0) begin
            prst_q  <= 1'b0;
            trig_q  <= 1'b1;
            phase_q <= PH_SETTLE;
            state_q <= ST_FIRE;
          end else begin
            phase_q <= phase_q - PH_W'(1);
          end
        end
        ST_FIRE: begin
          if (phase_q == '0) state_q <= ST_SAMPLE;
          else               phase_q <= phase_q - PH_W'(1);
        end
        ST_SAMPLE: begin
          for (int i = 0; i < RESP_W; i++) vote_q[i] <= vote_d[i];
          trig_q <= 1'b0;
          prst_q <= 1'b1;
          if (eval_q == LAST_EVAL) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            resp_q  <= resp_d;
            mask_q  <= mask_d;
            state_q <= ST_DONE;
          end else begin
            eval_q  <= eval_q + VOTE_W'(1);
            phase_q <= PH_RESET;
            state_q <= ST_ARM;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.response_out  = resp_q;
  assign bus.stable_mask   = mask_q;
  assign bus.puf_trigger   = trig_q;
  assign bus.puf_reset     = prst_q;
  assign bus.puf_challenge = chal_q;
  assign bus.puf_a         = a_q;
  assign bus.puf_b         = b_q;
endmodule
`default_nettype wire
